mips_multicycle_seq: RTL

- Parametrised multicycle sequencer for the MIPS datapath; successor to the fixed ID/EX/MEM/WB controller.
- Accepts one instruction word at a time over a valid/ready handshake and decodes it internally.
- Drives datapath control for a variable number of cycles per instruction class; waits on memory with a req/ack handshake.
- Owns the PC, including beq branch resolution, and flags illegal opcodes.

---
 rtl/mips_seq_pkg.sv | 42 ++++
 rtl/mips_multicycle_seq_if.sv | 29 ++
 rtl/mips_seq_decode.sv | 60 ++++++
 rtl/mips_multicycle_seq.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mips_seq_pkg.sv
// rtl/mips_seq_pkg.sv - shared encodings, FSM states and control bundle for the multicycle sequencer
package mips_seq_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ID,
    S_EX,
    S_MEM,
    S_WB
  } state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic [3:0] alu_ctrl;
    logic       is_ld;
    logic       is_st;
    logic       is_br;
    logic       is_wb;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_seq_if.sv
// rtl/mips_multicycle_seq_if.sv - instruction valid/ready and memory req/ack handshakes
interface mips_multicycle_seq_if;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instrword;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ack;

  modport master (
    input  instr_valid,
    input  instrword,
    input  mem_ack,
    output instr_ready,
    output mem_rd,
    output mem_wr
  );

  modport slave (
    output instr_valid,
    output instrword,
    output mem_ack,
    input  instr_ready,
    input  mem_rd,
    input  mem_wr
  );

endinterface

// File: rtl/mips_seq_decode.sv
// rtl/mips_seq_decode.sv - combinational IR to control-bundle decoder
module mips_seq_decode
  import mips_seq_pkg::*;
(
  input  logic [31:0] ir,
  output ctrl_t       ctrl
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_ir;

  assign op        = ir[31:26];
  assign fn        = ir[5:0];
  assign unused_ir = ^ir[25:6];

  always_comb begin
    ctrl = '0;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_dst = 1'b1;
        ctrl.is_wb   = 1'b1;
        case (fn)
          FN_ADD:  ctrl.alu_ctrl = ALU_ADD;
          FN_SUB:  ctrl.alu_ctrl = ALU_SUB;
          FN_AND:  ctrl.alu_ctrl = ALU_AND;
          FN_OR:   ctrl.alu_ctrl = ALU_OR;
          FN_SLT:  ctrl.alu_ctrl = ALU_SLT;
          default: begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_ctrl   = ALU_ADD;
        ctrl.is_ld      = 1'b1;
        ctrl.is_wb      = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src  = 1'b1;
        ctrl.alu_ctrl = ALU_ADD;
        ctrl.is_st    = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.is_br    = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_src  = 1'b1;
        ctrl.alu_ctrl = ALU_ADD;
        ctrl.is_wb    = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_seq.sv
// rtl/mips_multicycle_seq.sv - multicycle MIPS sequencer: FSM, PC, retire counter, handshakes
// MIPS_SEQ_MEM_TIMEOUT_EN adds a memory-ack timeout that aborts the access and pulses mem_err.
module mips_multicycle_seq
  import mips_seq_pkg::*;
#(
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              CNT_W       = 16,
  parameter int              TIMEOUT_CYC = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  mips_multicycle_seq_if.master   bus,
  input  logic                    alu_zero,
  output logic                    reg_dst,
  output logic                    alu_src,
  output logic                    mem_to_reg,
  output logic [3:0]              alu_ctrl,
  output logic                    reg_wr,
  output logic [PC_W-1:0]         pc,
  output logic                    illegal,
  output logic                    mem_err,
  output logic [CNT_W-1:0]        retired
);

  state_t           state_q;
  state_t           state_d;
  logic [31:0]      ir_q;
  ctrl_t            ctrl_q;
  ctrl_t            dec_ctrl;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_plus4;
  logic [PC_W-1:0]  br_off;
  logic [PC_W-1:0]  pc_next;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             tmo_hit;
  logic             dp_active;

  mips_seq_decode u_decode (
    .ir   (ir_q),
    .ctrl (dec_ctrl)
  );

  assign pc_plus4 = pc_q + PC_W'(4);
  assign br_off   = {{(PC_W-18){ir_q[15]}}, ir_q[15:0], 2'b00};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.instr_valid) state_d = S_ID;
      S_ID:   state_d = S_EX;
      S_EX: begin
        if (ctrl_q.is_ld || ctrl_q.is_st) state_d = S_MEM;
        else if (ctrl_q.is_wb)            state_d = S_WB;
        else                              state_d = S_IDLE;
      end
      S_MEM: begin
        // an ack on the timeout cycle takes priority over the timeout
        if (bus.mem_ack)  state_d = ctrl_q.is_ld ? S_WB : S_IDLE;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    retire  = 1'b0;
    pc_next = pc_plus4;
    case (state_q)
      S_EX: begin
        if (ctrl_q.is_br) begin
          retire = 1'b1;
          if (alu_zero) pc_next = pc_plus4 + br_off;
        end
      end
      S_MEM:   retire = ctrl_q.is_st && bus.mem_ack;
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      ctrl_q    <= '0;
      pc_q      <= RESET_PC;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.instr_valid) ir_q <= bus.instrword;
      if (state_q == S_ID) ctrl_q <= dec_ctrl;
      if (retire) begin
        pc_q      <= pc_next;
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

`ifdef MIPS_SEQ_MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             mem_err_q;

  assign tmo_hit = (state_q == S_MEM) && !bus.mem_ack &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= tmo_hit;
      if (state_q != S_MEM) tmo_cnt_q <= '0;
      else                  tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  assign mem_err = mem_err_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign tmo_hit        = 1'b0;
  assign mem_err        = 1'b0;
`endif

  // the registered bundle only reaches the datapath once it is valid
  assign dp_active = (state_q == S_EX) || (state_q == S_MEM) || (state_q == S_WB);

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.mem_rd      = (state_q == S_MEM) && ctrl_q.is_ld;
  assign bus.mem_wr      = (state_q == S_MEM) && ctrl_q.is_st;

  assign reg_dst    = dp_active && ctrl_q.reg_dst;
  assign alu_src    = dp_active && ctrl_q.alu_src;
  assign mem_to_reg = dp_active && ctrl_q.mem_to_reg;
  assign alu_ctrl   = dp_active ? ctrl_q.alu_ctrl : 4'b0000;
  assign reg_wr     = (state_q == S_WB);
  assign illegal    = (state_q == S_EX) && ctrl_q.illegal;
  assign pc         = pc_q;
  assign retired    = retired_q;

endmodule
